// File: rtl/rho_pkg.sv
// Shared definitions for the rho rotation stage.
//   rho_state_e : FSM state encoding (IDLE, LOAD, EMIT)
//   RHO_R       : per-lane rho rotation offsets, indexed by lane = 5*y + x
//   lane_idx    : helper mapping (x, y) to the lane index
package rho_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } rho_state_e;

  localparam int NumLanes = 25;

  // Offsets are for a 64-slice lane; users reduce them mod the actual lane length.
  localparam int unsigned RHO_R [NumLanes] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  function automatic int lane_idx(input int x, input int y);
    return 5 * y + x;
  endfunction

endpackage

// File: rtl/slice_buffer.sv
// Count x 25 register file holding one full state, one slice per entry.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset (clears all entries)
//   we         : write enable
//   waddr      : slice index to write
//   wdata      : 25-bit slice to write
//   raddr      : 25 packed read addresses, lane i uses raddr[i*CntBits +: CntBits]
//   rdata      : bit i is lane i of the entry addressed by its own read address
module slice_buffer
  import rho_pkg::*;
#(
  parameter int Count   = 64,
  parameter int CntBits = $clog2(Count)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [CntBits-1:0]            waddr,
  input  logic [NumLanes-1:0]           wdata,
  input  logic [NumLanes*CntBits-1:0]   raddr,
  output logic [NumLanes-1:0]           rdata
);

  logic [NumLanes-1:0] mem [Count];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < Count; k++) begin
        mem[k] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Each lane reads a single bit from its own slice, so the rotation is
  // realised purely by addressing.
  for (genvar i = 0; i < NumLanes; i++) begin : g_rd
    assign rdata[i] = mem[raddr[i*CntBits +: CntBits]][i];
  end

endmodule

// File: rtl/rho_rotator.sv
// Rho rotation stage: buffers Count 25-bit slices, then streams them back
// with every lane rotated along z by its rho offset.
// Optional feature macro: RHO_OUTREG_EN registers matrixOut/outValid/done
// (each one cycle later); default build drives them combinationally.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   start      : one-cycle begin request, sampled only in IDLE
//   matrixIn   : incoming slice, bit i = lane i (i = 5*y + x)
//   inReq      : matrixIn is latched this cycle (LOAD)
//   matrixOut  : rotated output slice, 0 when not valid
//   outValid   : matrixOut valid this cycle (EMIT); no backpressure
//   done       : one-cycle pulse on the last output slice
//   ready      : high in IDLE
//   fsm_state  : current FSM state (debug observation)
// Handshake: a run is a single-cycle start while ready=1; thereafter the block
// takes exactly one slice per cycle while inReq=1 and produces exactly one per
// cycle while outValid=1, with no stalls in either direction.
module rho_rotator
  import rho_pkg::*;
#(
  parameter int Count = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NumLanes-1:0] matrixIn,
  output logic                inReq,
  output logic [NumLanes-1:0] matrixOut,
  output logic                outValid,
  output logic                done,
  output logic                ready,
  output logic [1:0]          fsm_state
);

  localparam int CntBits = $clog2(Count);
  localparam logic [CntBits-1:0] LastSc = CntBits'(Count - 1);

  rho_state_e           state, state_next;
  logic [CntBits-1:0]   sc, sc_next;
  logic                 emit_valid, emit_done;
  logic [NumLanes*CntBits-1:0] raddr;
  logic [NumLanes-1:0]  rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sc    <= '0;
    end else begin
      state <= state_next;
      sc    <= sc_next;
    end
  end

  always_comb begin
    state_next = state;
    sc_next    = sc;
    inReq      = 1'b0;
    emit_valid = 1'b0;
    emit_done  = 1'b0;
    ready      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = LOAD;
          sc_next    = '0;
        end
      end
      LOAD: begin
        inReq   = 1'b1;
        sc_next = sc + 1'b1;
        if (sc == LastSc) begin
          state_next = EMIT;
          sc_next    = '0;
        end
      end
      EMIT: begin
        emit_valid = 1'b1;
        sc_next    = sc + 1'b1;
        if (sc == LastSc) begin
          emit_done  = 1'b1;
          state_next = IDLE;
          sc_next    = '0;
        end
      end
      default: begin
        state_next = IDLE;
        sc_next    = '0;
      end
    endcase
  end

  assign fsm_state = state;

  // Output slice z, lane i comes from input slice (z - R[i]) mod Count.
  // Count is a power of two, so truncating R[i] to CntBits is the mod.
  for (genvar y = 0; y < 5; y++) begin : g_y
    for (genvar x = 0; x < 5; x++) begin : g_x
      localparam int Lane = lane_idx(x, y);
      localparam logic [CntBits-1:0] Rot = CntBits'(RHO_R[Lane]);
      assign raddr[Lane*CntBits +: CntBits] = sc - Rot;
    end
  end

  slice_buffer #(
    .Count   (Count),
    .CntBits (CntBits)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (inReq),
    .waddr (sc),
    .wdata (matrixIn),
    .raddr (raddr),
    .rdata (rdata)
  );

`ifdef RHO_OUTREG_EN
  logic [NumLanes-1:0] mout_q;
  logic                valid_q;
  logic                done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mout_q  <= emit_valid ? rdata : '0;
      valid_q <= emit_valid;
      done_q  <= emit_done;
    end
  end

  assign matrixOut = mout_q;
  assign outValid  = valid_q;
  assign done      = done_q;
`else
  assign matrixOut = emit_valid ? rdata : '0;
  assign outValid  = emit_valid;
  assign done      = emit_done;
`endif

endmodule

// File: tb/tb_rho_rotator.sv
module tb_rho_rotator;

  localparam int Count = 64;
`ifdef RHO_OUTREG_EN
  localparam int Lat = 1;
`else
  localparam int Lat = 0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [24:0] matrixIn;
  logic        inReq;
  logic [24:0] matrixOut;
  logic        outValid;
  logic        done;
  logic        ready;
  logic [1:0]  fsm_state;

  rho_rotator #(.Count(Count)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .matrixIn  (matrixIn),
    .inReq     (inReq),
    .matrixOut (matrixOut),
    .outValid  (outValid),
    .done      (done),
    .ready     (ready),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [24:0] exp_q[$];
  logic [24:0] in_slices [Count];

  // Rho offsets typed in independently of the design package.
  int rho_tab [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                       41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  typedef struct {
    int in_k;   // input slice carrying the single set bit
    int lane;   // lane of that bit
    int out_z;  // hand-computed output slice where it must appear
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Runs one full LOAD/EMIT pass from IDLE using in_slices; output data is
  // compared against exp_q. Optionally pokes start mid-LOAD and mid-EMIT.
  task automatic do_run(input bit poke_start);
    logic [24:0] e;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < Count; k++) begin
      if (k == 0) check("state_load", 32'(fsm_state), 32'd1);
      check("inReq_load", 32'(inReq), 32'd1);
      check("ready_load", 32'(ready), 32'd0);
      matrixIn = in_slices[k];
      start = poke_start && (k == 10);
      step();
    end
    start = 1'b0;
    matrixIn = '0;
    if (Lat == 1) begin
      check("outValid_lat", 32'(outValid), 32'd0);
      step();
    end
    for (int z = 0; z < Count; z++) begin
      if (z == 0 && Lat == 0) check("state_emit", 32'(fsm_state), 32'd2);
      check("outValid_emit", 32'(outValid), 32'd1);
      check("done_emit", 32'(done), 32'(z == Count - 1));
      check("ready_emit", 32'(ready), 32'((z == Count - 1) && (Lat == 1)));
      check("inReq_emit", 32'(inReq), 32'd0);
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("data_z%0d", z), 32'(matrixOut), 32'(e));
      end
      start = poke_start && (z == 20);
      step();
    end
    start = 1'b0;
    check("ready_after", 32'(ready), 32'd1);
    check("outValid_after", 32'(outValid), 32'd0);
    check("done_after", 32'(done), 32'd0);
    check("matrixOut_after", 32'(matrixOut), 32'd0);
    step();
    check("still_idle", 32'(inReq), 32'd0);
  endtask

  task automatic load_parity();
    logic [24:0] e;
    int src;
    for (int k = 0; k < Count; k++) in_slices[k] = {25{k[0]}};
    for (int z = 0; z < Count; z++) begin
      e = '0;
      for (int i = 0; i < 25; i++) begin
        src = (z - rho_tab[i] + Count) % Count;
        e[i] = src[0];
      end
      exp_q.push_back(e);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [24:0] one_hot;
    vecs[0] = '{in_k: 0,  lane: 1,  out_z: 1};
    vecs[1] = '{in_k: 0,  lane: 2,  out_z: 62};
    vecs[2] = '{in_k: 0,  lane: 24, out_z: 14};
    vecs[3] = '{in_k: 0,  lane: 0,  out_z: 0};
    vecs[4] = '{in_k: 5,  lane: 3,  out_z: 33};
    vecs[5] = '{in_k: 60, lane: 6,  out_z: 40};
    vecs[6] = '{in_k: 63, lane: 22, out_z: 60};
    vecs[7] = '{in_k: 10, lane: 12, out_z: 53};
    vecs[8] = '{in_k: 40, lane: 23, out_z: 32};

    rst = 1'b0;
    start = 1'b0;
    matrixIn = '0;
    step();
    step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_inReq", 32'(inReq), 32'd0);
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_matrixOut", 32'(matrixOut), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    rst = 1'b1;
    step();
    step();
    check("idle_no_start", 32'(ready), 32'd1);

    // All-zero state.
    for (int k = 0; k < Count; k++) in_slices[k] = '0;
    for (int z = 0; z < Count; z++) exp_q.push_back('0);
    do_run(1'b0);

    // Single-bit impulses with hand-computed destinations.
    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < Count; k++) in_slices[k] = '0;
      one_hot = '0;
      one_hot[vecs[v].lane] = 1'b1;
      in_slices[vecs[v].in_k] = one_hot;
      for (int z = 0; z < Count; z++) exp_q.push_back((z == vecs[v].out_z) ? one_hot : 25'd0);
      do_run(1'b0);
    end

    // Alternating slices, with start poked mid-LOAD and mid-EMIT.
    load_parity();
    do_run(1'b1);

    // Reset asserted during LOAD cycle 30.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      matrixIn = 25'($urandom_range(32'h1ff_ffff, 0));
      step();
    end
    check("abort_inReq_pre", 32'(inReq), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_inReq", 32'(inReq), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_outValid", 32'(outValid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_matrixOut", 32'(matrixOut), 32'd0);
    check("abort_state", 32'(fsm_state), 32'd0);
    matrixIn = '0;
    step();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      check("post_abort_idle", 32'(ready), 32'd1);
      check("post_abort_inReq", 32'(inReq), 32'd0);
    end

    // Full run after the abort.
    load_parity();
    do_run(1'b0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
